fetch_pc_ctrl: RTL and testbench

//  Consumer end of the branch-target path. Owns the architectural fetch PC, issues
//  32-bit instruction fetches to IMEM via a req/ready handshake, and applies redirects

---
 rtl/fetch_pc_ctrl_pkg.sv | 16 +
 rtl/fetch_pc_ctrl_if.sv | 13 +
 rtl/fetch_pc_ctrl.sv | 91 +++++++++
 tb/tb_fetch_pc_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller: FSM states, PC step
// and reset address defaults.
package fetch_pc_ctrl_pkg;

  localparam int REG_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
  localparam logic [REG_BUS-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back in the
// same cycle.
interface fetch_pc_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC owner: issues word fetches to IMEM, presents results to IF/ID and
// applies EX-stage redirects with a one-cycle flush pulse.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = REG_BUS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_valid,
  input  logic [ADDR_W-1:0]     branch_addr,
  input  logic                  stall,
  fetch_pc_ctrl_if.master       imem,
  output logic                  if_valid,
  output logic [ADDR_W-1:0]     if_pc,
  output logic [31:0]           if_inst,
  output logic                  flush,
  output logic                  misalign
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_d;
  logic [ADDR_W-1:0] if_pc_d;
  logic [31:0]       if_inst_d;
  logic              flush_d;
  logic              misalign_d;
  logic              redirect;

  // The address is taken straight from the PC register so it stays stable
  // for as long as a request waits on ready.
  assign imem.req  = (state_q == FETCH) && !stall;
  assign imem.addr = pc_q;

  assign redirect = branch_valid && (state_q != BOOT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = if_valid;
    if_pc_d    = if_pc;
    if_inst_d  = if_inst;
    flush_d    = 1'b0;
    misalign_d = 1'b0;

    // A redirect beats stall and drops any response arriving the same cycle.
    if (redirect) begin
      pc_d       = {branch_addr[ADDR_W-1:2], 2'b00};
      flush_d    = 1'b1;
      misalign_d = |branch_addr[1:0];
      valid_d    = 1'b0;
      state_d    = REDIR;
    end else begin
      case (state_q)
        BOOT:  state_d = FETCH;
        REDIR: state_d = FETCH;
        FETCH: begin
          if (imem.ready && !stall) begin
            if_inst_d = imem.rdata;
            if_pc_d   = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + ADDR_W'(PC_STEP);
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC[ADDR_W-1:0];
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= ZERO_WORD;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      if_valid <= valid_d;
      if_pc    <= if_pc_d;
      if_inst  <= if_inst_d;
      flush    <= flush_d;
      misalign <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural fetch model.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        branch_valid;
  logic [31:0] branch_addr;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
  logic        misalign;

  int tests;
  int failures;

  fetch_pc_ctrl_if #(.ADDR_W(32)) bus ();

  fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_valid (branch_valid),
    .branch_addr  (branch_addr),
    .stall        (stall),
    .imem         (bus.master),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .flush        (flush),
    .misalign     (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // IMEM returns data in the same cycle as ready.
  assign bus.rdata = mem_word(bus.addr);

  // Behavioural model: the PC being fetched, whether we sit in the start-up
  // gap or the post-redirect bubble, and what IF/ID should currently show.
  logic [31:0] m_pc;
  bit          m_booting;
  bit          m_bubble;
  logic        m_valid;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic        m_flush;
  logic        m_misalign;

  logic        obs_req, exp_req;
  logic [31:0] obs_addr, exp_addr;

  // Drive one cycle, snapshot the combinational fetch request mid-cycle, then
  // advance the model on the edge and settle just after it.
  task automatic step(input logic rn, input logic bv, input logic [31:0] ba,
                      input logic st, input logic rdy);
    rst          = rn;
    branch_valid = bv;
    branch_addr  = ba;
    stall        = st;
    bus.ready    = rdy;
    #1;
    obs_req  = bus.req;
    obs_addr = bus.addr;
    exp_req  = !m_booting && !m_bubble && !st;
    exp_addr = m_pc;
    @(posedge clk);
    if (!rn) begin
      m_pc = 32'h0; m_booting = 1; m_bubble = 0;
      m_valid = 0; m_if_pc = 0; m_if_inst = 0; m_flush = 0; m_misalign = 0;
    end else if (bv && !m_booting) begin
      m_pc = ba & 32'hFFFF_FFFC;
      m_flush = 1;
      m_misalign = (ba % 4) != 0;
      m_valid = 0;
      m_bubble = 1;
    end else begin
      m_flush = 0;
      m_misalign = 0;
      if (m_booting) m_booting = 0;
      else if (m_bubble) m_bubble = 0;
      else if (rdy && !st) begin
        m_if_inst = mem_word(m_pc);
        m_if_pc = m_pc;
        m_valid = 1;
        m_pc = m_pc + 4;
      end
    end
    #1;
  endtask

  task automatic idle(input logic st, input logic rdy);
    step(1'b1, 1'b0, 32'h0, st, rdy);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++;
    if ({if_valid, flush, misalign} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {if_valid, flush, misalign});
    end
    tests++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_if: if_pc=%h if_inst=%h expected 0/0", if_pc, if_inst);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL boot_no_req: req=%b expected 0", obs_req);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL first_fetch: req=%b addr=%h expected 1/00000000", obs_req, obs_addr);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1'b1);
      tests++;
      if (obs_req !== 1'b1 || obs_addr !== 32'(4 * i)) begin
        failures++;
        $display("[TB] FAIL stream_req[%0d]: req=%b addr=%h expected 1/%h", i, obs_req, obs_addr, 32'(4 * i));
      end
      tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_inst !== mem_word(32'(4 * i))) begin
        failures++;
        $display("[TB] FAIL stream_out[%0d]: valid=%b pc=%h inst=%h expected 1/%h/%h",
                 i, if_valid, if_pc, if_inst, 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
    tests++;
    if (obs_addr !== 32'h8) begin
      failures++;
      $display("[TB] FAIL redir_at_pc: addr=%h expected 00000008", obs_addr);
    end
    tests++;
    if (flush !== 1'b1 || if_valid !== 1'b0 || if_pc !== 32'h4) begin
      failures++;
      $display("[TB] FAIL redir_flush: flush=%b valid=%b if_pc=%h expected 1/0/00000004", flush, if_valid, if_pc);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_req !== 1'b0 || flush !== 1'b0) begin
      failures++;
      $display("[TB] FAIL redir_bubble: req=%b flush=%b expected 0/0", obs_req, flush);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
      failures++;
      $display("[TB] FAIL redir_target: req=%b addr=%h expected 1/00000100", obs_req, obs_addr);
    end
  endtask

  task automatic test_stall_branch();
    do_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    tests++;
    if (obs_req !== 1'b0 || if_pc !== 32'h4 || if_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_hold: req=%b if_pc=%h valid=%b expected 0/00000004/1", obs_req, if_pc, if_valid);
    end
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
    tests++;
    if (flush !== 1'b1 || if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_branch: flush=%b valid=%b expected 1/0", flush, if_valid);
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    tests++;
    if (obs_req !== 1'b0 || obs_addr !== 32'h40) begin
      failures++;
      $display("[TB] FAIL stall_target_held: req=%b addr=%h expected 0/00000040", obs_req, obs_addr);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h40 || if_pc !== 32'h40 || if_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release: req=%b addr=%h if_pc=%h valid=%b expected 1/00000040/00000040/1",
               obs_req, obs_addr, if_pc, if_valid);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    tests++;
    if (misalign !== 1'b1 || flush !== 1'b1) begin
      failures++;
      $display("[TB] FAIL misalign_pulse: misalign=%b flush=%b expected 1/1", misalign, flush);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (misalign !== 1'b0) begin
      failures++;
      $display("[TB] FAIL misalign_single: misalign=%b expected 0", misalign);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_addr !== 32'hFFFF_FFFC || if_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("[TB] FAIL top_word: addr=%h if_pc=%h expected fffffffc/fffffffc", obs_addr, if_pc);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_addr !== 32'h0 || if_pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL pc_wrap: addr=%h if_pc=%h expected 00000000/00000000", obs_addr, if_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
    tests++;
    if (flush !== 1'b1 || obs_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_flush: flush=%b req=%b expected 1/0", flush, obs_req);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_req !== 1'b0 || flush !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_bubble: req=%b flush=%b expected 0/0", obs_req, flush);
    end
    idle(1'b0, 1'b1);
    tests++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h300) begin
      failures++;
      $display("[TB] FAIL b2b_target: req=%b addr=%h expected 1/00000300", obs_req, obs_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tests++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || flush !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midwait_reset: valid=%b pc=%h inst=%h flush=%b mis=%b expected all 0",
               if_valid, if_pc, if_inst, flush, misalign);
    end
    idle(1'b0, 1'b0);
    tests++;
    if (obs_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midwait_boot: req=%b expected 0", obs_req);
    end
    idle(1'b0, 1'b0);
    tests++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midwait_restart: req=%b addr=%h expected 1/00000000", obs_req, obs_addr);
    end
  endtask

  task automatic test_random();
    logic        rn, bv, st, rdy;
    logic [31:0] ba;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rn  = ($urandom_range(0, 59) != 0);
      bv  = ($urandom_range(0, 7) == 0);
      ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      st  = ($urandom_range(0, 3) == 0);
      rdy = 1'($urandom_range(0, 1));
      step(rn, bv, ba, st, rdy);
      tests++;
      if (obs_req !== exp_req || obs_addr !== exp_addr) begin
        failures++;
        $display("[TB] FAIL rand_req[%0d]: req=%b addr=%h expected %b/%h", i, obs_req, obs_addr, exp_req, exp_addr);
      end
      tests++;
      if (if_valid !== m_valid || if_pc !== m_if_pc || if_inst !== m_if_inst) begin
        failures++;
        $display("[TB] FAIL rand_if[%0d]: valid=%b pc=%h inst=%h expected %b/%h/%h",
                 i, if_valid, if_pc, if_inst, m_valid, m_if_pc, m_if_inst);
      end
      tests++;
      if (flush !== m_flush || misalign !== m_misalign) begin
        failures++;
        $display("[TB] FAIL rand_pulse[%0d]: flush=%b mis=%b expected %b/%b", i, flush, misalign, m_flush, m_misalign);
      end
    end
  endtask

  initial begin
    tests        = 0;
    failures     = 0;
    rst          = 1'b0;
    branch_valid = 1'b0;
    branch_addr  = 32'h0;
    stall        = 1'b0;
    bus.ready    = 1'b0;
    m_pc = 0; m_booting = 1; m_bubble = 0;
    m_valid = 0; m_if_pc = 0; m_if_inst = 0; m_flush = 0; m_misalign = 0;

    test_reset();
    test_streaming();
    test_redirect();
    test_stall_branch();
    test_boundary();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
